// File: rtl/pa_clint_mtime_gen.sv
// Machine timer source for the CLINT: prescaled free-running 64-bit mtime with
// M-mode half-word writes and a hi-word snapshot for torn-free 32-bit reads.
module pa_clint_mtime_gen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clint_clk,
   input  logic                 clint_rst,
   input  logic                 mtime_en,
   input  logic [DIV_WIDTH-1:0] mtime_div,
   input  logic                 dbg_halt,
   input  logic [1:0]           cpu_clint_mode,
   input  logic                 busif_mtime_write_vld,
   input  logic                 busif_mtime_lo_sel,
   input  logic                 busif_mtime_hi_sel,
   input  logic [31:0]          busif_mtime_wdata,
   input  logic                 busif_mtime_lo_rd,
   output logic [63:0]          sysio_clint_mtime,
   output logic [31:0]          mtime_hi_snap,
   output logic                 mtime_tick,
   output logic                 mtime_wrap
);

   localparam logic [1:0] M_MODE = 2'b11;

   logic [63:0]          mtime_r;
   logic [63:0]          mtime_nxt_s;
   logic [DIV_WIDTH-1:0] pre_cnt_r;
   logic [DIV_WIDTH-1:0] pre_cnt_nxt_s;
   logic [31:0]          hi_snap_r;
   logic [31:0]          hi_snap_nxt_s;
   logic                 tick_r;
   logic                 tick_nxt_s;
   logic                 wrap_r;
   logic                 wrap_nxt_s;
   logic                 wr_vld_s;
   logic                 tick_due_s;

   // An increment from the all-ones value is the only way mtime wraps to zero.
   function automatic logic is_wrap_point(input logic [63:0] value);
      return (value == 64'hFFFF_FFFF_FFFF_FFFF);
   endfunction

   // Write qualification: only M-mode writes that select at least one half count.
   always_comb begin
      wr_vld_s   = busif_mtime_write_vld && (cpu_clint_mode == M_MODE) &&
                   (busif_mtime_lo_sel || busif_mtime_hi_sel);
      tick_due_s = (pre_cnt_r >= mtime_div);
   end

   // Next-state selection in priority order: write, disable, halt, count.
   always_comb begin
      mtime_nxt_s   = mtime_r;
      pre_cnt_nxt_s = pre_cnt_r;
      tick_nxt_s    = 1'b0;
      wrap_nxt_s    = 1'b0;
      if (wr_vld_s) begin
         if (busif_mtime_lo_sel) begin
            mtime_nxt_s[31:0] = busif_mtime_wdata;
         end else begin
            mtime_nxt_s[31:0] = mtime_r[31:0];
         end
         if (busif_mtime_hi_sel) begin
            mtime_nxt_s[63:32] = busif_mtime_wdata;
         end else begin
            mtime_nxt_s[63:32] = mtime_r[63:32];
         end
         pre_cnt_nxt_s = {DIV_WIDTH{1'b0}};
      end else if (!mtime_en) begin
         pre_cnt_nxt_s = {DIV_WIDTH{1'b0}};
      end else if (dbg_halt) begin
         pre_cnt_nxt_s = pre_cnt_r;
      end else if (tick_due_s) begin
         // >= rather than == so lowering mtime_div below pre_cnt still ticks.
         pre_cnt_nxt_s = {DIV_WIDTH{1'b0}};
         mtime_nxt_s   = mtime_r + 64'd1;
         tick_nxt_s    = 1'b1;
         wrap_nxt_s    = is_wrap_point(mtime_r);
      end else begin
         pre_cnt_nxt_s = pre_cnt_r + DIV_WIDTH'(1);
      end
   end

   // Snapshot takes the pre-update hi word so it pairs with the lo word read now.
   always_comb begin
      if (busif_mtime_lo_rd) begin
         hi_snap_nxt_s = mtime_r[63:32];
      end else begin
         hi_snap_nxt_s = hi_snap_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clint_clk) begin
      if (clint_rst) begin
         mtime_r   <= 64'd0;
         pre_cnt_r <= {DIV_WIDTH{1'b0}};
         hi_snap_r <= 32'd0;
         tick_r    <= 1'b0;
         wrap_r    <= 1'b0;
      end else begin
         mtime_r   <= mtime_nxt_s;
         pre_cnt_r <= pre_cnt_nxt_s;
         hi_snap_r <= hi_snap_nxt_s;
         tick_r    <= tick_nxt_s;
         wrap_r    <= wrap_nxt_s;
      end
   end

   assign sysio_clint_mtime = mtime_r;
   assign mtime_hi_snap     = hi_snap_r;
   assign mtime_tick        = tick_r;
   assign mtime_wrap        = wrap_r;

endmodule

// File: tb/tb_pa_clint_mtime_gen.sv
// Directed plus randomized bench for pa_clint_mtime_gen against an arithmetic model.
module tb_pa_clint_mtime_gen;

   logic        clint_clk = 1'b0;
   logic        clint_rst;
   logic        mtime_en;
   logic [7:0]  mtime_div;
   logic        dbg_halt;
   logic [1:0]  cpu_clint_mode;
   logic        busif_mtime_write_vld;
   logic        busif_mtime_lo_sel;
   logic        busif_mtime_hi_sel;
   logic [31:0] busif_mtime_wdata;
   logic        busif_mtime_lo_rd;
   logic [63:0] sysio_clint_mtime;
   logic [31:0] mtime_hi_snap;
   logic        mtime_tick;
   logic        mtime_wrap;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state
   logic [63:0] m_mtime = 64'd0;
   int unsigned m_phase = 0;
   logic [31:0] m_snap  = 32'd0;
   logic        m_tick  = 1'b0;
   logic        m_wrap  = 1'b0;

   pa_clint_mtime_gen #(.DIV_WIDTH(8)) dut (
      .clint_clk             (clint_clk),
      .clint_rst             (clint_rst),
      .mtime_en              (mtime_en),
      .mtime_div             (mtime_div),
      .dbg_halt              (dbg_halt),
      .cpu_clint_mode        (cpu_clint_mode),
      .busif_mtime_write_vld (busif_mtime_write_vld),
      .busif_mtime_lo_sel    (busif_mtime_lo_sel),
      .busif_mtime_hi_sel    (busif_mtime_hi_sel),
      .busif_mtime_wdata     (busif_mtime_wdata),
      .busif_mtime_lo_rd     (busif_mtime_lo_rd),
      .sysio_clint_mtime     (sysio_clint_mtime),
      .mtime_hi_snap         (mtime_hi_snap),
      .mtime_tick            (mtime_tick),
      .mtime_wrap            (mtime_wrap)
   );

   always #5 clint_clk = ~clint_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model by one cycle from the currently driven inputs.
   task automatic model_cycle();
      bit wr;
      wr = busif_mtime_write_vld && (cpu_clint_mode == 2'd3) &&
           (busif_mtime_lo_sel || busif_mtime_hi_sel);
      m_tick = 1'b0;
      m_wrap = 1'b0;
      if (clint_rst) begin
         m_mtime = 64'd0; m_phase = 0; m_snap = 32'd0;
      end else begin
         if (busif_mtime_lo_rd) m_snap = m_mtime[63:32];
         if (wr) begin
            if (busif_mtime_lo_sel) m_mtime[31:0]  = busif_mtime_wdata;
            if (busif_mtime_hi_sel) m_mtime[63:32] = busif_mtime_wdata;
            m_phase = 0;
         end else if (!mtime_en) begin
            m_phase = 0;
         end else if (!dbg_halt) begin
            if (m_phase >= int'(mtime_div)) begin
               m_phase = 0;
               m_wrap  = (m_mtime == 64'hFFFF_FFFF_FFFF_FFFF);
               m_mtime = m_mtime + 64'd1;
               m_tick  = 1'b1;
            end else begin
               m_phase = m_phase + 1;
            end
         end
      end
   endtask

   task automatic step();
      model_cycle();
      @(posedge clint_clk);
      #1;
      chk("mtime", sysio_clint_mtime, m_mtime);
      chk("hi_snap", {32'd0, mtime_hi_snap}, {32'd0, m_snap});
      chk("tick", {63'd0, mtime_tick}, {63'd0, m_tick});
      chk("wrap", {63'd0, mtime_wrap}, {63'd0, m_wrap});
   endtask

   task automatic wr(input logic lo, input logic hi, input logic [31:0] d);
      busif_mtime_write_vld = 1'b1;
      busif_mtime_lo_sel    = lo;
      busif_mtime_hi_sel    = hi;
      busif_mtime_wdata     = d;
      step();
      busif_mtime_write_vld = 1'b0;
      busif_mtime_lo_sel    = 1'b0;
      busif_mtime_hi_sel    = 1'b0;
   endtask

   initial begin
      clint_rst = 1'b1; mtime_en = 1'b0; mtime_div = 8'd0; dbg_halt = 1'b0;
      cpu_clint_mode = 2'b11; busif_mtime_write_vld = 1'b0; busif_mtime_lo_sel = 1'b0;
      busif_mtime_hi_sel = 1'b0; busif_mtime_wdata = 32'd0; busif_mtime_lo_rd = 1'b0;

      step(); step();
      chk("rst_mtime", sysio_clint_mtime, 64'd0);
      chk("rst_snap", {32'd0, mtime_hi_snap}, 64'd0);

      // Divide-by-4 counting after reset release
      clint_rst = 1'b0; mtime_en = 1'b1; mtime_div = 8'd3;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("div4_tick", {63'd0, mtime_tick}, (i % 4 == 0) ? 64'd1 : 64'd0);
         if (i == 4) chk("div4_m1", sysio_clint_mtime, 64'd1);
         if (i == 8) chk("div4_m2", sysio_clint_mtime, 64'd2);
      end

      // Wrap from all-ones
      mtime_div = 8'd0;
      wr(1'b1, 1'b0, 32'hFFFF_FFFE);
      wr(1'b0, 1'b1, 32'hFFFF_FFFF);
      chk("wr_both", sysio_clint_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      chk("pre_wrap", sysio_clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("pre_wrap_flag", {63'd0, mtime_wrap}, 64'd0);
      step();
      chk("wrap_val", sysio_clint_mtime, 64'd0);
      chk("wrap_flag", {63'd0, mtime_wrap}, 64'd1);
      step();
      chk("post_wrap_flag", {63'd0, mtime_wrap}, 64'd0);

      // Write beats a due tick
      wr(1'b1, 1'b0, 32'h10);
      chk("wr_tick_val", sysio_clint_mtime, 64'h10);
      chk("wr_tick_pulse", {63'd0, mtime_tick}, 64'd0);
      step();
      chk("wr_then_inc", sysio_clint_mtime, 64'h11);

      // Non-M-mode write is ignored and leaves the phase alone
      mtime_div = 8'd3; mtime_en = 1'b0;
      step();
      mtime_en = 1'b1;
      step();
      cpu_clint_mode = 2'b00;
      wr(1'b1, 1'b1, 32'hDEAD_BEEF);
      cpu_clint_mode = 2'b11;
      step();
      chk("umode_hold", sysio_clint_mtime, 64'h11);
      chk("umode_notick", {63'd0, mtime_tick}, 64'd0);
      step();
      chk("umode_tick", {63'd0, mtime_tick}, 64'd1);
      chk("umode_inc", sysio_clint_mtime, 64'h12);

      // Snapshot taken in the carry cycle keeps the old hi word
      mtime_div = 8'd0;
      wr(1'b1, 1'b0, 32'hFFFF_FFFF);
      wr(1'b0, 1'b1, 32'h1);
      busif_mtime_lo_rd = 1'b1;
      step();
      busif_mtime_lo_rd = 1'b0;
      chk("carry_val", sysio_clint_mtime, 64'h2_0000_0000);
      chk("carry_snap", {32'd0, mtime_hi_snap}, 64'h1);

      // Halt freezes phase; lowered divide after disable
      mtime_div = 8'd7; mtime_en = 1'b0;
      step();
      mtime_en = 1'b1;
      for (int i = 0; i < 5; i++) step();
      dbg_halt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("halt_hold", sysio_clint_mtime, 64'h2_0000_0000);
      end
      dbg_halt = 1'b0;
      step(); chk("rel_t1", {63'd0, mtime_tick}, 64'd0);
      step(); chk("rel_t2", {63'd0, mtime_tick}, 64'd0);
      step(); chk("rel_t3", {63'd0, mtime_tick}, 64'd1);
      chk("rel_val", sysio_clint_mtime, 64'h2_0000_0001);
      mtime_en = 1'b0;
      step();
      mtime_div = 8'd2; mtime_en = 1'b1;
      step(); chk("div3_t1", {63'd0, mtime_tick}, 64'd0);
      step(); chk("div3_t2", {63'd0, mtime_tick}, 64'd0);
      step(); chk("div3_t3", {63'd0, mtime_tick}, 64'd1);
      chk("div3_val", sysio_clint_mtime, 64'h2_0000_0002);
      step();
      clint_rst = 1'b1;
      step();
      chk("midrst_mtime", sysio_clint_mtime, 64'd0);
      chk("midrst_snap", {32'd0, mtime_hi_snap}, 64'd0);
      chk("midrst_tick", {63'd0, mtime_tick}, 64'd0);
      clint_rst = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         clint_rst             = ($urandom_range(0, 299) == 0);
         mtime_en              = ($urandom_range(0, 9) != 0);
         mtime_div             = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 3));
         dbg_halt              = ($urandom_range(0, 7) == 0);
         cpu_clint_mode        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         busif_mtime_write_vld = ($urandom_range(0, 9) == 0);
         busif_mtime_lo_sel    = 1'($urandom_range(0, 1));
         busif_mtime_hi_sel    = 1'($urandom_range(0, 1));
         busif_mtime_wdata     = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         busif_mtime_lo_rd     = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
